stream_mux: RTL and testbench

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshake on every input and on the output.
Successor to the combinational 2:1/4:1 datapath muxes: adds arbitrary channel count, a one-entry output register and two selection modes.
- Fixed mode: the select input picks the channel.
- Round-robin mode: an internal fair arbiter picks the channel.
Sits between multi-source producers (e.g. writeback/forwarding sources, memory request ports) and a single consumer.

---
 rtl/stream_mux_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/stream_mux.sv | 155 +++++++++++++++
 tb/tb_stream_mux.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_pkg
// Description : Shared constants for the stream_mux block (mode encoding and
//               statistics counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int STATS_W = 16;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Fair round-robin arbiter. Searches the request vector from the
//               priority pointer upward with wrap-around; the pointer moves to
//               the slot after the winner only when advance is pulsed.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic                grant_valid,
    output logic [SEL_W-1:0]    grant_idx
);

    localparam logic [SEL_W:0]   c_chan = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] c_last = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W:0]   w_idx;

    // Wrap-around search; offsets are scanned from the far end so the one
    // closest to the pointer is the last to write and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_idx       = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            w_idx = {1'b0, ptr_q} + k[SEL_W:0];
            if (w_idx >= c_chan) begin
                w_idx = w_idx - c_chan;
            end
            if (req[w_idx[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = w_idx[SEL_W-1:0];
            end
        end
    end

    // Pointer moves past the winner only on an accepted round-robin transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == c_last) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux
// Description : N-channel registered stream multiplexer with valid/ready on
//               every port. Fixed-select or round-robin channel selection
//               feeding a one-entry output register.
//               Optional macro STREAM_MUX_STATS_EN adds per-channel saturating
//               transfer counters on port grant_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef STREAM_MUX_STATS_EN
    ,
    output logic [CHANNELS*STATS_W-1:0] grant_cnt
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;

    logic             w_can_load;
    logic             w_fix_valid;
    logic [SEL_W-1:0] w_fix_idx;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_grant_valid;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_transfer;
    logic [WIDTH-1:0] w_sel_data;

    // A new beat may enter when the register is empty or is being drained now.
    assign w_can_load = !out_valid_q || out_ready;

    // Fixed select: compare against every real channel so an out-of-range
    // sel simply matches nothing.
    always_comb begin
        w_fix_valid = 1'b0;
        w_fix_idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_fix_valid = 1'b1;
                w_fix_idx   = SEL_W'(i);
            end
        end
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .req         (in_valid),
        .advance     (w_transfer && (mode == MODE_RR)),
        .grant_valid (w_rr_valid),
        .grant_idx   (w_rr_idx)
    );

    assign w_grant_valid = (mode == MODE_RR) ? w_rr_valid : w_fix_valid;
    assign w_grant_idx   = (mode == MODE_RR) ? w_rr_idx   : w_fix_idx;
    assign w_transfer    = !rst && w_can_load && w_grant_valid;

    // One-hot ready toward the granted channel only.
    always_comb begin
        in_ready = '0;
        if (w_transfer) begin
            in_ready[w_grant_idx] = 1'b1;
        end
    end

    // Data select for the granted channel.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant_idx == SEL_W'(i)) begin
                w_sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register next state: load replaces, pop empties, stall holds.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (w_transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_chan_d  = w_grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

`ifdef STREAM_MUX_STATS_EN
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_stats
        logic [STATS_W-1:0] cnt_q, cnt_d;

        // Saturating count of beats loaded from this channel.
        always_comb begin
            cnt_d = cnt_q;
            if (w_transfer && w_grant_idx == SEL_W'(gi) && cnt_q != '1) begin
                cnt_d = cnt_q + STATS_W'(1);
            end
        end

        // Counter register.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign grant_cnt[gi*STATS_W +: STATS_W] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux
// Description : Self-checking bench for stream_mux. A 4-channel and a
//               3-channel instance run side by side against a transaction-level
//               reference model. Define STREAM_MUX_STATS_EN to also cover the
//               transfer counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 4-channel instance signals
    logic [127:0] d4_in_data;
    logic [3:0]   d4_in_valid, d4_in_ready;
    logic         d4_mode;
    logic [1:0]   d4_sel;
    logic [31:0]  d4_out_data;
    logic [1:0]   d4_out_chan;
    logic         d4_out_valid, d4_out_ready;

    // 3-channel instance signals
    logic [95:0]  d3_in_data;
    logic [2:0]   d3_in_valid, d3_in_ready;
    logic         d3_mode;
    logic [1:0]   d3_sel;
    logic [31:0]  d3_out_data;
    logic [1:0]   d3_out_chan;
    logic         d3_out_valid, d3_out_ready;

`ifdef STREAM_MUX_STATS_EN
    logic [63:0]  d4_grant_cnt;
    logic [47:0]  d3_grant_cnt;
`endif

    stream_mux #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d4_in_data),
        .in_valid  (d4_in_valid),
        .in_ready  (d4_in_ready),
        .mode      (d4_mode),
        .sel       (d4_sel),
        .out_data  (d4_out_data),
        .out_chan  (d4_out_chan),
        .out_valid (d4_out_valid),
        .out_ready (d4_out_ready)
`ifdef STREAM_MUX_STATS_EN
        ,
        .grant_cnt (d4_grant_cnt)
`endif
    );

    stream_mux #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d3_in_data),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .mode      (d3_mode),
        .sel       (d3_sel),
        .out_data  (d3_out_data),
        .out_chan  (d3_out_chan),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready)
`ifdef STREAM_MUX_STATS_EN
        ,
        .grant_cnt (d3_grant_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = 4-channel, 1 = 3-channel instance
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    int          m_chan  [2];
    int          m_ptr   [2];
    int          m_cnt   [2][4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge of behaviour, computed from the channel rules directly.
    task automatic model_step(input int id, input int n, input logic [3:0] iv,
                              input logic [127:0] data, input logic md, input int sel,
                              input logic ordy, output logic [3:0] exp_rdy);
        int g;
        g       = -1;
        exp_rdy = '0;
        if (rst) begin
            m_valid[id] = 1'b0;
            m_data[id]  = '0;
            m_chan[id]  = 0;
            m_ptr[id]   = 0;
            for (int c = 0; c < 4; c++) m_cnt[id][c] = 0;
            return;
        end
        if (md) begin
            for (int k = 0; k < n; k++) begin
                int i;
                i = (m_ptr[id] + k) % n;
                if (g < 0 && iv[i]) g = i;
            end
        end else if (sel < n && iv[sel]) begin
            g = sel;
        end
        if (g >= 0 && (!m_valid[id] || ordy)) begin
            exp_rdy[g]  = 1'b1;
            m_valid[id] = 1'b1;
            m_data[id]  = data[g*32 +: 32];
            m_chan[id]  = g;
            if (md) m_ptr[id] = (g + 1) % n;
            if (m_cnt[id][g] < 65535) m_cnt[id][g]++;
        end else if (ordy) begin
            m_valid[id] = 1'b0;
        end
    endtask

    // Inputs are already applied; check readies, let one edge pass, check outputs.
    task automatic cycle();
        logic [3:0] er4, er3;
        #1;
        model_step(0, 4, d4_in_valid, d4_in_data, d4_mode, int'(d4_sel), d4_out_ready, er4);
        model_step(1, 3, {1'b0, d3_in_valid}, {32'h0, d3_in_data}, d3_mode, int'(d3_sel),
                   d3_out_ready, er3);
        check("d4_in_ready", 64'(d4_in_ready), 64'(er4));
        check("d3_in_ready", 64'(d3_in_ready), 64'(er3[2:0]));
        @(negedge clk);
        check("d4_out_valid", 64'(d4_out_valid), 64'(m_valid[0]));
        check("d4_out_data",  64'(d4_out_data),  64'(m_data[0]));
        check("d4_out_chan",  64'(d4_out_chan),  64'(m_chan[0]));
        check("d3_out_valid", 64'(d3_out_valid), 64'(m_valid[1]));
        check("d3_out_data",  64'(d3_out_data),  64'(m_data[1]));
        check("d3_out_chan",  64'(d3_out_chan),  64'(m_chan[1]));
`ifdef STREAM_MUX_STATS_EN
        for (int c = 0; c < 4; c++) check("d4_grant_cnt", 64'(d4_grant_cnt[c*16 +: 16]), 64'(m_cnt[0][c]));
        for (int c = 0; c < 3; c++) check("d3_grant_cnt", 64'(d3_grant_cnt[c*16 +: 16]), 64'(m_cnt[1][c]));
`endif
    endtask

    task automatic idle_inputs();
        d4_in_valid = '0; d4_mode = 1'b0; d4_sel = '0; d4_out_ready = 1'b1;
        d3_in_valid = '0; d3_mode = 1'b0; d3_sel = '0; d3_out_ready = 1'b1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_data[d] = '0; m_chan[d] = 0; m_ptr[d] = 0;
            for (int c = 0; c < 4; c++) m_cnt[d][c] = 0;
        end
        rst        = 1'b1;
        d4_in_data = '0;
        d3_in_data = '0;
        idle_inputs();

        // Reset, then idle with no valid inputs
        repeat (3) cycle();
        check("rst_d4_in_ready", 64'(d4_in_ready), 64'h0);
        rst = 1'b0;
        repeat (3) cycle();

        // Fixed select picks channel 2 out of two valid channels
        d4_in_data[64 +: 32] = 32'hCAFE0002;
        d4_in_data[32 +: 32] = 32'h11111111;
        d4_in_valid = 4'b0110;
        d4_sel      = 2'd2;
        cycle();
        check("t2_out_data", 64'(d4_out_data), 64'hCAFE0002);
        check("t2_out_chan", 64'(d4_out_chan), 64'd2);
        idle_inputs();
        cycle();

        // Round-robin over four always-valid channels
        d4_mode     = 1'b1;
        d4_in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            d4_in_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            check("t3_rr_chan",  64'(d4_out_chan),  64'(k % 4));
            check("t3_rr_valid", 64'(d4_out_valid), 64'd1);
        end
        idle_inputs();
        cycle();

        // Round-robin wrap on the 3-channel instance
        d3_mode     = 1'b1;
        d3_in_data  = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
        d3_in_valid = 3'b100;
        cycle();
        check("t4_first_chan", 64'(d3_out_chan), 64'd2);
        d3_in_valid = 3'b101;
        cycle();
        check("t4_wrap_chan", 64'(d3_out_chan), 64'd0);
        idle_inputs();
        cycle();

        // Output stall holds beat A, then B loads as the stall releases
        d4_sel = 2'd1;
        d4_in_valid = 4'b0010;
        d4_in_data[32 +: 32] = 32'hAAAA0001;
        cycle();
        d4_out_ready = 1'b0;
        d4_in_data[32 +: 32] = 32'hBBBB0001;
        repeat (3) begin
            cycle();
            check("t5_stall_data",  64'(d4_out_data), 64'hAAAA0001);
            check("t5_stall_ready", 64'(d4_in_ready), 64'h0);
        end
        d4_out_ready = 1'b1;
        cycle();
        check("t5_b_data",  64'(d4_out_data),  64'hBBBB0001);
        check("t5_b_valid", 64'(d4_out_valid), 64'd1);
        idle_inputs();
        cycle();

        // Out-of-range select on 3 channels never grants
        d3_sel      = 2'd3;
        d3_in_valid = 3'b111;
        repeat (4) begin
            cycle();
            check("t6_sel3_ready", 64'(d3_in_ready), 64'h0);
        end
        idle_inputs();

        // Reset during a stall discards the held beat
        d4_in_valid  = 4'b0001;
        cycle();
        d4_in_valid  = '0;
        d4_out_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t6_rst_valid", 64'(d4_out_valid), 64'd0);
        idle_inputs();
        cycle();

        // Randomised traffic on both instances
        for (int n = 0; n < 2000; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            d4_in_data   = {$urandom, $urandom, $urandom, $urandom};
            d3_in_data   = {$urandom, $urandom, $urandom};
            d4_in_valid  = 4'($urandom);
            d3_in_valid  = 3'($urandom);
            d4_mode      = 1'($urandom);
            d3_mode      = 1'($urandom);
            d4_sel       = 2'($urandom);
            d3_sel       = 2'($urandom);
            d4_out_ready = ($urandom_range(0, 3) != 0);
            d3_out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

`ifdef STREAM_MUX_STATS_EN
        // Counter saturation after more than 65535 channel-0 transfers
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        d4_in_valid = 4'b0001;
        for (int n = 0; n < 70000; n++) cycle();
        check("stats_sat", 64'(d4_grant_cnt[15:0]), 64'hFFFF);
        idle_inputs();
        cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
